// File: rtl/debug_data_transmitter.sv
// ============================================================================
// Module      : debug_data_transmitter
// Description : Serialises DATA_WIDTH-bit debug words MSB first behind a
//               one-cycle data_start strobe, with a one-entry holding buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_data_transmitter #(
    parameter int DATA_WIDTH = 40,
    parameter int GAP_CYCLES = 3
) (
    input  logic                  debug_clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  data_start,
    output logic                  sout,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // The receiver needs at least three idle cycles to re-arm.
    if (GAP_CYCLES < 3 || DATA_WIDTH < 1) begin : g_param_check
        $error("debug_data_transmitter: GAP_CYCLES must be >= 3 and DATA_WIDTH >= 1");
    end

    logic [1:0]            state_q,    state_d;
    logic [DATA_WIDTH-1:0] shreg_q,    shreg_d;
    logic [DATA_WIDTH-1:0] buf_q,      buf_d;
    logic                  buf_full_q, buf_full_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [GAP_W-1:0]      gcnt_q,     gcnt_d;
    logic                  load;

    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            cnt_q      <= '0;
            gcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            cnt_q      <= cnt_d;
            gcnt_q     <= gcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        cnt_d      = cnt_q;
        gcnt_d     = gcnt_q;
        load       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (buf_full_q) begin
                    state_d = S_START;
                    load    = 1'b1;
                end
            end
            S_START: begin
                state_d = S_SHIFT;
                cnt_d   = '0;
            end
            S_SHIFT: begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_GAP;
                    gcnt_d  = '0;
                end
            end
            S_GAP: begin
                gcnt_d = gcnt_q + GAP_W'(1);
                if (gcnt_q == GAP_LAST) begin
                    if (buf_full_q) begin
                        state_d = S_START;
                        load    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            shreg_d    = buf_q;
            buf_full_d = 1'b0;
        end

        // A drain needs buf_full_q, an accept needs !buf_full_q: never both.
        if (in_valid && !buf_full_q) begin
            buf_d      = in_data;
            buf_full_d = 1'b1;
        end
    end

    always_comb begin
        in_ready   = !buf_full_q;
        data_start = (state_q == S_START);
        sout       = (state_q == S_SHIFT) && shreg_q[DATA_WIDTH-1];
        tx_done    = (state_q == S_GAP) && (gcnt_q == '0);
        busy       = (state_q != S_IDLE) || buf_full_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_debug_data_transmitter.sv
// ============================================================================
// Module      : tb_debug_data_transmitter
// Description : Self-checking bench: frame-position reference model, loopback
//               receiver and a small-parameter instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debug_data_transmitter;

    localparam int W     = 40;
    localparam int G     = 3;
    localparam int FRAME = 1 + W + G;
    localparam int W8    = 8;
    localparam int G8    = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready, data_start, sout, busy, tx_done;

    logic [W8-1:0] in_data8;
    logic          in_valid8;
    logic          in_ready8, data_start8, sout8, busy8, tx_done8;

    always #5 clk = ~clk;

    debug_data_transmitter #(.DATA_WIDTH(W), .GAP_CYCLES(G)) u_dut (
        .debug_clk (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_start(data_start),
        .sout      (sout),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    debug_data_transmitter #(.DATA_WIDTH(W8), .GAP_CYCLES(G8)) u_dut8 (
        .debug_clk (clk),
        .reset     (reset),
        .in_data   (in_data8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .data_start(data_start8),
        .sout      (sout8),
        .busy      (busy8),
        .tx_done   (tx_done8)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired t=%0t", name, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: position inside the current frame (-1 = line idle),
    // frame = 1 strobe cycle, W data cycles, G gap cycles.
    int           m_pos = -1;
    logic [W-1:0] m_cur = '0;
    logic [W-1:0] m_buf = '0;
    bit           m_bfull = 1'b0;
    int           m_accepts = 0;
    logic [W-1:0] sent_q[$];

    always @(posedge clk or posedge reset) begin
        bit acc;
        if (reset) begin
            m_pos   = -1;
            m_bfull = 1'b0;
            sent_q.delete();
        end else begin
            acc = in_valid && !m_bfull;
            if (m_pos == -1 || m_pos == FRAME - 1) begin
                if (m_bfull) begin
                    m_cur   = m_buf;
                    m_bfull = 1'b0;
                    m_pos   = 0;
                end else begin
                    m_pos = -1;
                end
            end else begin
                m_pos++;
            end
            if (acc) begin
                m_buf   = in_data;
                m_bfull = 1'b1;
                sent_q.push_back(in_data);
                m_accepts++;
            end
        end
    end

    always @(negedge clk) begin
        logic e_ds, e_sout, e_done, e_busy;
        if (chk_en) begin
            e_ds   = (m_pos == 0);
            e_sout = (m_pos >= 1 && m_pos <= W) ? m_cur[W - m_pos] : 1'b0;
            e_done = (m_pos == W + 1);
            e_busy = (m_pos != -1) || m_bfull;
            check("data_start", data_start, e_ds);
            check("sout",       sout,       e_sout);
            check("tx_done",    tx_done,    e_done);
            check("busy",       busy,       e_busy);
            check("in_ready",   in_ready,   !m_bfull);
        end
    end

    // Loopback receiver: shifts sout into bit 0 on each cycle after data_start.
    bit           rx_armed = 1'b0;
    int           rx_cnt = 0;
    logic [W-1:0] rx_sh = '0;
    logic [W-1:0] rx_log[$];
    int           ds_q[$];
    int           td_q[$];

    always @(negedge clk) begin
        if (reset) begin
            rx_armed = 1'b0;
        end else if (data_start) begin
            rx_armed = 1'b1;
            rx_cnt   = 0;
            ds_q.push_back(cyc);
        end else if (rx_armed) begin
            rx_sh = {rx_sh[W-2:0], sout};
            rx_cnt++;
            if (rx_cnt == W) begin
                rx_armed = 1'b0;
                rx_log.push_back(rx_sh);
                if (sent_q.size() > 0) begin
                    check("loopback", rx_sh, sent_q.pop_front());
                end else begin
                    total++;
                    bad++;
                    $display("FAIL rx_extra: actual=%0h expected=none", rx_sh);
                end
            end
        end
        if (!reset && tx_done) td_q.push_back(cyc);
    end

    int            k8 = W8;
    logic [W8-1:0] sh8 = '0;
    logic [W8-1:0] rx8_q[$];
    int            ds8_q[$];

    always @(negedge clk) begin
        if (reset) begin
            k8 = W8;
        end else if (data_start8) begin
            ds8_q.push_back(cyc);
            k8 = 0;
        end else if (k8 < W8) begin
            sh8 = {sh8[W8-2:0], sout8};
            k8++;
            if (k8 == W8) rx8_q.push_back(sh8);
        end
    end

    task automatic clear_logs();
        rx_log.delete();
        ds_q.delete();
        td_q.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] w);
        int n;
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        while (m_bfull && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail("send_timeout");
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(m_pos == -1 && !m_bfull) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) fail("idle_timeout");
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] wa, wb, wc;
        int n, badsp, acc0;

        in_valid  = 1'b0;
        in_data   = '0;
        in_valid8 = 1'b0;
        in_data8  = '0;
        reset     = 1'b0;
        #1 reset  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",   in_ready,   1);
        check("rst_data_start", data_start, 0);
        check("rst_sout",       sout,       0);
        check("rst_busy",       busy,       0);
        check("rst_tx_done",    tx_done,    0);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Single word from idle
        clear_logs();
        send(40'hA5_0F_C3_96_81);
        in_valid = 1'b0;
        wait_idle();
        check("t1_ds_count",   ds_q.size(), 1);
        check("t1_done_count", td_q.size(), 1);
        if (ds_q.size() == 1 && td_q.size() == 1)
            check("t1_done_offset", td_q[0] - ds_q[0], 41);
        if (rx_log.size() == 1)
            check("t1_word", rx_log[0], 40'hA5_0F_C3_96_81);
        else
            check("t1_rx_count", rx_log.size(), 1);

        // Two words with in_valid held high
        clear_logs();
        send(40'hFF_FFFF_FFFF);
        send(40'h00_0000_0001);
        in_valid = 1'b0;
        wait_idle();
        check("t2_ds_count", ds_q.size(), 2);
        if (ds_q.size() == 2) check("t2_spacing", ds_q[1] - ds_q[0], 44);
        if (rx_log.size() == 2) begin
            check("t2_word0", rx_log[0], 40'hFF_FFFF_FFFF);
            check("t2_word1", rx_log[1], 40'h00_0000_0001);
        end else begin
            check("t2_rx_count", rx_log.size(), 2);
        end

        // 20 random words back-to-back
        clear_logs();
        for (int i = 0; i < 20; i++) send(rnd_word());
        in_valid = 1'b0;
        wait_idle();
        check("t3_rx_count", rx_log.size(), 20);
        badsp = 0;
        for (int i = 1; i < ds_q.size(); i++)
            if (ds_q[i] - ds_q[i-1] != FRAME) badsp++;
        check("t3_spacing_errors", badsp, 0);

        // Reset mid-SHIFT with the buffer full
        clear_logs();
        wa = rnd_word();
        wb = rnd_word();
        send(wa);
        send(wb);
        in_valid = 1'b0;
        n = 0;
        while (m_pos != W - 17 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail("t4_pos_timeout");
        check("t4_pre_in_ready", in_ready, 0);
        #2 reset = 1'b1;
        #1;
        check("t4_rst_sout",       sout,       0);
        check("t4_rst_data_start", data_start, 0);
        check("t4_rst_busy",       busy,       0);
        check("t4_rst_in_ready",   in_ready,   1);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        clear_logs();
        wc = rnd_word();
        send(wc);
        in_valid = 1'b0;
        wait_idle();
        check("t4_ds_count", ds_q.size(), 1);
        if (rx_log.size() == 1) check("t4_word", rx_log[0], wc);
        else                    check("t4_rx_count", rx_log.size(), 1);

        // in_valid toggling every cycle while idle
        clear_logs();
        acc0 = m_accepts;
        for (int f = 0; f < 10; f++) begin
            wait_idle();
            for (int c = 0; c < 4; c++) begin
                in_valid = (c % 2 == 0);
                in_data  = rnd_word();
                @(negedge clk);
            end
            in_valid = 1'b0;
        end
        wait_idle();
        check("t5_accepts",  m_accepts - acc0, 20);
        check("t5_rx_count", rx_log.size(), 20);

        // Small-parameter instance
        ds8_q.delete();
        rx8_q.delete();
        check("t6_ready_idle", in_ready8, 1);
        in_valid8 = 1'b1;
        in_data8  = 8'h3C;
        @(negedge clk);
        in_data8 = 8'hA5;
        n = 0;
        while (!in_ready8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail("t6_ready_timeout");
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_ds_count", ds8_q.size(), 2);
        if (ds8_q.size() == 2) check("t6_spacing", ds8_q[1] - ds8_q[0], 14);
        if (rx8_q.size() == 2) begin
            check("t6_word0", rx8_q[0], 8'h3C);
            check("t6_word1", rx8_q[1], 8'hA5);
        end else begin
            check("t6_rx_count", rx8_q.size(), 2);
        end
        check("t6_idle_busy", busy8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
